// File: rtl/seg_ctrl_pkg.sv
// Shared definitions for the seven-segment display arbiter: FSM states,
// the blank digit code and the 16-bit digit packing.
package seg_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GAP,
    ST_OWN
  } state_e;

  localparam logic [3:0]  BLANK_DIGIT = 4'hA;
  localparam logic [15:0] BLANK_WORD  = {4{BLANK_DIGIT}};

  localparam int unsigned DIGIT_W  = 4;
  localparam int unsigned DIG0_LSB = 0;
  localparam int unsigned DIG1_LSB = 4;
  localparam int unsigned DIG2_LSB = 8;
  localparam int unsigned DIG3_LSB = 12;

endpackage

// File: rtl/seg_display_arbiter_if.sv
// Requester-side and display-side signals of the display arbiter.
interface seg_display_arbiter_if;
  logic        req0;
  logic [15:0] data0;
  logic        req1;
  logic [15:0] data1;
  logic        gnt0;
  logic        gnt1;
  logic [3:0]  val3;
  logic [3:0]  val2;
  logic [3:0]  val1;
  logic [3:0]  val0;
  logic        blank;

  modport master (
    output req0, data0, req1, data1,
    input  gnt0, gnt1, val3, val2, val1, val0, blank
  );

  modport slave (
    input  req0, data0, req1, data1,
    output gnt0, gnt1, val3, val2, val1, val0, blank
  );
endinterface

// File: rtl/seg_hold_timer.sv
// Loadable down-counter that saturates at zero and flags when it is there.
module seg_hold_timer #(
  parameter int unsigned CNT_W = 26
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/seg_display_arbiter.sv
// Round-robin owner of the shared 4-digit display with a minimum hold
// time per owner and a blanked gap before each new owner is shown.
module seg_display_arbiter
  import seg_ctrl_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES  = 50_000_000,
  parameter int unsigned BLANK_CYCLES = 65_536,
  parameter int unsigned CNT_W        = 26
) (
  input  logic                 clk,
  input  logic                 rst_n,
  seg_display_arbiter_if.slave bus
);

  localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYCLES - 1);

  state_e      state_q, state_d;
  logic        pend_q, pend_d;
  logic        last_q, last_d;
  logic [1:0]  gnt_q, gnt_d;
  logic [15:0] vals_q, vals_d;
  logic        blank_q, blank_d;

  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_zero;

  logic [1:0]  req;
  logic [15:0] data_pend;
  logic [15:0] data_own;

  assign req       = {bus.req1, bus.req0};
  assign data_pend = pend_q ? bus.data1 : bus.data0;
  // The owner is always the most recently granted requester.
  assign data_own  = last_q ? bus.data1 : bus.data0;

  seg_hold_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    last_d   = last_q;
    gnt_d    = gnt_q;
    vals_d   = vals_q;
    blank_d  = blank_q;
    tmr_load = 1'b0;
    tmr_val  = '0;

    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          // A lone requester wins outright; a tie goes to the one not served last.
          pend_d   = (&req) ? ~last_q : req[1];
          state_d  = ST_GAP;
          tmr_load = 1'b1;
          tmr_val  = BLANK_LOAD;
        end
      end

      ST_GAP: begin
        if (tmr_zero) begin
          if (req[pend_q]) begin
            state_d  = ST_OWN;
            gnt_d    = pend_q ? 2'b10 : 2'b01;
            blank_d  = 1'b0;
            vals_d   = data_pend;
            last_d   = pend_q;
            tmr_load = 1'b1;
            tmr_val  = HOLD_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      ST_OWN: begin
        if (!req[last_q]) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
          blank_d = 1'b1;
          vals_d  = BLANK_WORD;
        end else if (tmr_zero && req[~last_q]) begin
          state_d  = ST_GAP;
          pend_d   = ~last_q;
          gnt_d    = '0;
          blank_d  = 1'b1;
          vals_d   = BLANK_WORD;
          tmr_load = 1'b1;
          tmr_val  = BLANK_LOAD;
        end else begin
          vals_d = data_own;
        end
      end

      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        blank_d = 1'b1;
        vals_d  = BLANK_WORD;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pend_q  <= 1'b0;
      last_q  <= 1'b1;
      gnt_q   <= '0;
      vals_q  <= BLANK_WORD;
      blank_q <= 1'b1;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      vals_q  <= vals_d;
      blank_q <= blank_d;
    end
  end

  assign bus.gnt0  = gnt_q[0];
  assign bus.gnt1  = gnt_q[1];
  assign bus.blank = blank_q;
  assign bus.val3  = vals_q[DIG3_LSB +: DIGIT_W];
  assign bus.val2  = vals_q[DIG2_LSB +: DIGIT_W];
  assign bus.val1  = vals_q[DIG1_LSB +: DIGIT_W];
  assign bus.val0  = vals_q[DIG0_LSB +: DIGIT_W];

endmodule

// File: doc/seg_display_arbiter.md
Name: seg_display_arbiter

Overview:
Shares the board's single 4-digit seven-segment display between two requesters, e.g. a counter readout and a status/message source. It grants ownership round-robin and enforces a minimum hold time so digits stay readable. A blanked gap is inserted between owners to avoid ghosting. It drives the four 4-bit digit values and a blank flag into the existing multiplexed display driver, where digit code 4'hA renders as all segments off.

Parameters:
HOLD_CYCLES, 50_000_000, minimum clk cycles an owner keeps the display once granted (>=1; 0.5 s at 100 MHz)
BLANK_CYCLES, 65_536, clk cycles of blanked gap before a new owner is shown (>=1; one full scan frame)
CNT_W, 26, timer width; must hold max(HOLD_CYCLES, BLANK_CYCLES)-1

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous, active-low reset
req0  in  1  requester 0 wants the display (level, held while wanted)
data0  in  16  requester 0 digits, [15:12]=digit3 ... [3:0]=digit0
req1  in  1  requester 1 wants the display
data1  in  16  requester 1 digits, same packing
gnt0  out  1  requester 0 currently shown
gnt1  out  1  requester 1 currently shown
val3, val2, val1, val0  out  4 each  digit values to display driver
blank  out  1  high while no owner is shown

Behaviour:
- All outputs registered. Reset (async, rst_n=0): state IDLE, gnt0=gnt1=0, val3..val0=4'hA, blank=1, timer=0, pend=0, last=1 (requester 0 wins the first tie).
- States: IDLE, GAP, OWN. Timer is a down-counter that saturates at 0.
- IDLE: if any req, choose the winner; if both, choose the one != last. pend<=winner, timer<=BLANK_CYCLES-1, go GAP. Otherwise stay. Outputs stay blank.
- GAP: decrement timer. At an edge where timer==0: if req[pend] is high, go OWN, gnt[pend]<=1, blank<=0, val<=data[pend], last<=pend, timer<=HOLD_CYCLES-1. If req[pend] is low, go IDLE (abort), outputs stay blank.
- Latency: req sampled at edge t (from IDLE) gives gnt high after edge t+BLANK_CYCLES.
- OWN: each edge val<=data[owner], giving 1-cycle latency on live data. Timer decrements to 0 and holds there.
  - Priority 1: req[owner]==0 -> IDLE; same edge gnt<=0, blank<=1, vals<=4'hA. This is immediate release, ignoring the hold.
  - Priority 2: timer==0 and req[other]==1 -> GAP, pend<=other, timer<=BLANK_CYCLES-1; gnt<=0, blank<=1, vals<=4'hA.
  - Otherwise stay. A lone owner keeps the display indefinitely.
- Simultaneous owner drop and other request: release wins (go IDLE). The next edge arbitrates from IDLE and the other requester wins, since last=owner.
- gnt0 and gnt1 are never high together. blank == ~(gnt0|gnt1) at all times.
- Reset asserted mid-operation clears everything asynchronously. After deassertion, arbitration restarts from IDLE with last=1.

Decomposition:
- Package seg_ctrl_pkg: state encoding (IDLE/GAP/OWN), BLANK_DIGIT=4'hA, digit-field slice constants for the 16-bit packing.
- One sub-module, seg_hold_timer: loadable CNT_W down-counter with saturation and a zero flag; async active-low reset.
- The arbiter FSM and the output registers stay in the top.

Test Plan (BLANK_CYCLES=4, HOLD_CYCLES=8):
1. Reset -> gnt0=gnt1=0, blank=1, val3..val0=A,A,A,A; rst_n low held with req0=1 -> no grant.
2. req0=1 sampled at edge 0, data0=16'h1234 -> gnt0 high after edge 4, val3..0=1,2,3,4, blank=0; data0->16'h5678 at edge 6 -> vals 5,6,7,8 after edge 6.
3. From case 2, req1=1 (data1=16'h9ABC) asserted at edge 5, req0 held -> gnt0 drops after edge 12 (blank, vals=A); gnt1 high after edge 16, vals 9,A,B,C.
4. req0 and req1 both rise at the same edge from reset -> gnt0 first. Drop req0 and reassert both -> gnt1 wins the next tie.
5. Owner requester 0 drops req0 at edge 7 (mid-hold), req1 high -> gnt0=0 and blank=1 after edge 7; IDLE picks requester 1; gnt1 after edge 12. In a separate run, req1 drops during GAP -> return to IDLE, no grant.
6. rst_n pulsed low mid-OWN -> gnt0=0, blank=1, vals=A immediately without a clock edge; after release, req0 is regranted 4 cycles later.
